// File: rtl/sha2_pkg.sv
// Shared SHA-2 definitions: schedule FSM states, legal round counts and the
// rotate/shift amounts of the small-sigma functions for both word widths.
package sha2_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        EXPAND = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    localparam int ROUNDS_W32 = 64;
    localparam int ROUNDS_W64 = 80;

    localparam int S0_R1_W32 = 7;
    localparam int S0_R2_W32 = 18;
    localparam int S0_SH_W32 = 3;
    localparam int S1_R1_W32 = 17;
    localparam int S1_R2_W32 = 19;
    localparam int S1_SH_W32 = 10;

    localparam int S0_R1_W64 = 1;
    localparam int S0_R2_W64 = 8;
    localparam int S0_SH_W64 = 7;
    localparam int S1_R1_W64 = 19;
    localparam int S1_R2_W64 = 61;
    localparam int S1_SH_W64 = 6;

    function automatic int legal_rounds(input int word_w);
        return (word_w == 64) ? ROUNDS_W64 : ROUNDS_W32;
    endfunction

    // kind: 0 = first rotate, 1 = second rotate, 2 = plain right shift.
    function automatic int sigma_amt(input int word_w, input int sel, input int kind);
        int amt;
        amt = 0;
        if (word_w == 64) begin
            case ({sel[0], kind[1:0]})
                3'b000:  amt = S0_R1_W64;
                3'b001:  amt = S0_R2_W64;
                3'b010:  amt = S0_SH_W64;
                3'b100:  amt = S1_R1_W64;
                3'b101:  amt = S1_R2_W64;
                default: amt = S1_SH_W64;
            endcase
        end else begin
            case ({sel[0], kind[1:0]})
                3'b000:  amt = S0_R1_W32;
                3'b001:  amt = S0_R2_W32;
                3'b010:  amt = S0_SH_W32;
                3'b100:  amt = S1_R1_W32;
                3'b101:  amt = S1_R2_W32;
                default: amt = S1_SH_W32;
            endcase
        end
        return amt;
    endfunction

endpackage

// File: rtl/sha2_small_sigma.sv
// Combinational SHA-2 small sigma: SEL=0 gives s0, SEL=1 gives s1.
// Pure XOR of two rotates and one logical shift.
module sha2_small_sigma
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int SEL    = 0
) (
    input  logic [WORD_W-1:0] i_x,
    output logic [WORD_W-1:0] o_y
);

    localparam int R1 = sigma_amt(WORD_W, SEL, 0);
    localparam int R2 = sigma_amt(WORD_W, SEL, 1);
    localparam int SH = sigma_amt(WORD_W, SEL, 2);

    logic [WORD_W-1:0] w_rot1;
    logic [WORD_W-1:0] w_rot2;
    logic [WORD_W-1:0] w_shr;

    assign w_rot1 = (i_x >> R1) | (i_x << (WORD_W - R1));
    assign w_rot2 = (i_x >> R2) | (i_x << (WORD_W - R2));
    assign w_shr  = i_x >> SH;
    assign o_y    = w_rot1 ^ w_rot2 ^ w_shr;

endmodule

// File: rtl/msg_schedule_expander.sv
// SHA-2 message schedule: loads a 16-word block, then streams W[0..ROUNDS-1]
// from a 16-entry circular buffer through a single output register.
module msg_schedule_expander
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              load_valid,
    input  logic [WORD_W-1:0] load_word,
    output logic              load_ready,
    output logic              w_valid,
    output logic [WORD_W-1:0] w_word,
    output logic [6:0]        w_index,
    input  logic              w_ready,
    output logic              busy,
    output logic              block_done,
    output logic [1:0]        dbg_state
);

    if (!((WORD_W == 32 || WORD_W == 64) && ROUNDS == legal_rounds(WORD_W))) begin : g_bad_cfg
        $error("msg_schedule_expander: unsupported WORD_W/ROUNDS pairing");
    end

    localparam logic [6:0] LAST_T = 7'(ROUNDS - 1);

    state_t            r_state;
    logic [6:0]        r_t;
    logic              r_out_valid;
    logic [WORD_W-1:0] r_out_word;
    logic [6:0]        r_out_index;
    logic [WORD_W-1:0] r_buf [16];

    logic              w_slot_free;
    logic              w_load_acc;
    logic              w_exp_issue;
    logic              w_last_hs;
    logic [3:0]        w_slot;
    logic [3:0]        w_load_slot;
    logic [3:0]        w_slot_m2;
    logic [3:0]        w_slot_m7;
    logic [3:0]        w_slot_m15;
    logic [WORD_W-1:0] w_s0;
    logic [WORD_W-1:0] w_s1;
    logic [WORD_W-1:0] w_expanded;

    // A transfer happens on a rising edge where valid and ready are both high;
    // the output register may be refilled whenever it is empty or being taken.
    assign w_slot_free = !r_out_valid || w_ready;
    assign load_ready  = ((r_state == LOAD) || (r_state == DRAIN)) && w_slot_free;
    assign w_load_acc  = load_valid && load_ready;
    assign w_exp_issue = (r_state == EXPAND) && w_slot_free;
    assign w_last_hs   = (r_state == DRAIN) && r_out_valid && w_ready;

    // Leaving DRAIN restarts at t=0 even though r_t still holds ROUNDS-1.
    assign w_slot      = r_t[3:0];
    assign w_load_slot = (r_state == DRAIN) ? 4'd0 : w_slot;
    assign w_slot_m2   = w_slot - 4'd2;
    assign w_slot_m7   = w_slot - 4'd7;
    assign w_slot_m15  = w_slot + 4'd1;

    sha2_small_sigma #(.WORD_W(WORD_W), .SEL(0)) u_sigma0 (
        .i_x (r_buf[w_slot_m15]),
        .o_y (w_s0)
    );

    sha2_small_sigma #(.WORD_W(WORD_W), .SEL(1)) u_sigma1 (
        .i_x (r_buf[w_slot_m2]),
        .o_y (w_s1)
    );

    assign w_expanded = w_s1 + r_buf[w_slot_m7] + w_s0 + r_buf[w_slot];

    always_ff @(posedge clock) begin
        if (reset && !flush) begin
            if (w_load_acc) begin
                r_buf[w_load_slot] <= load_word;
            end else if (w_exp_issue) begin
                r_buf[w_slot] <= w_expanded;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= LOAD;
            r_t         <= 7'd0;
            r_out_valid <= 1'b0;
            r_out_word  <= '0;
            r_out_index <= 7'd0;
        end else if (flush) begin
            r_state     <= LOAD;
            r_t         <= 7'd0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_slot_free) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                LOAD: begin
                    if (w_load_acc) begin
                        r_out_valid <= 1'b1;
                        r_out_word  <= load_word;
                        r_out_index <= r_t;
                        r_t         <= r_t + 7'd1;
                        if (r_t == 7'd15) begin
                            r_state <= EXPAND;
                        end
                    end
                end
                EXPAND: begin
                    if (w_exp_issue) begin
                        r_out_valid <= 1'b1;
                        r_out_word  <= w_expanded;
                        r_out_index <= r_t;
                        if (r_t == LAST_T) begin
                            r_state <= DRAIN;
                        end else begin
                            r_t <= r_t + 7'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (w_last_hs) begin
                        r_state <= LOAD;
                        if (w_load_acc) begin
                            r_out_valid <= 1'b1;
                            r_out_word  <= load_word;
                            r_out_index <= 7'd0;
                            r_t         <= 7'd1;
                        end else begin
                            r_t <= 7'd0;
                        end
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

    assign w_valid    = r_out_valid;
    assign w_word     = r_out_word;
    assign w_index    = r_out_index;
    assign block_done = w_last_hs && reset && !flush;
    assign busy       = (r_state != LOAD) || (r_t != 7'd0) || r_out_valid;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_msg_schedule_expander.sv
// Directed bench for msg_schedule_expander: SHA-256 and SHA-512 builds side by
// side, checked against a reference schedule model and hand-derived words.
module tb_msg_schedule_expander;

    logic        clock;
    logic        tb_reset;
    logic        tb_flush;
    logic        tb_lv;
    logic [63:0] tb_lw;
    logic        tb_wr;
    logic        sel64;

    logic        lr32, v32, busy32, done32;
    logic [31:0] wd32;
    logic [6:0]  ix32;
    logic [1:0]  st32;
    logic        lr64, v64, busy64, done64;
    logic [63:0] wd64;
    logic [6:0]  ix64;
    logic [1:0]  st64;

    logic        ob_valid, ob_lready, ob_busy, ob_done;
    logic [63:0] ob_word;
    logic [6:0]  ob_index;
    logic [1:0]  ob_state;

    logic [31:0] sig_x32, sig_s0_32, sig_s1_32;
    logic [63:0] sig_x64, sig_s0_64, sig_s1_64;

    int          checks;
    int          errors;
    logic [63:0] cap [80];
    logic [63:0] abc_w [16];
    logic [63:0] exp_q [$];
    logic [63:0] load_q [$];

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    msg_schedule_expander #(.WORD_W(32), .ROUNDS(64)) u_dut32 (
        .clock      (clock),
        .reset      (tb_reset),
        .flush      (tb_flush && !sel64),
        .load_valid (tb_lv && !sel64),
        .load_word  (tb_lw[31:0]),
        .load_ready (lr32),
        .w_valid    (v32),
        .w_word     (wd32),
        .w_index    (ix32),
        .w_ready    (tb_wr && !sel64),
        .busy       (busy32),
        .block_done (done32),
        .dbg_state  (st32)
    );

    msg_schedule_expander #(.WORD_W(64), .ROUNDS(80)) u_dut64 (
        .clock      (clock),
        .reset      (tb_reset),
        .flush      (tb_flush && sel64),
        .load_valid (tb_lv && sel64),
        .load_word  (tb_lw),
        .load_ready (lr64),
        .w_valid    (v64),
        .w_word     (wd64),
        .w_index    (ix64),
        .w_ready    (tb_wr && sel64),
        .busy       (busy64),
        .block_done (done64),
        .dbg_state  (st64)
    );

    sha2_small_sigma #(.WORD_W(32), .SEL(0)) u_sig0_32 (.i_x(sig_x32), .o_y(sig_s0_32));
    sha2_small_sigma #(.WORD_W(32), .SEL(1)) u_sig1_32 (.i_x(sig_x32), .o_y(sig_s1_32));
    sha2_small_sigma #(.WORD_W(64), .SEL(0)) u_sig0_64 (.i_x(sig_x64), .o_y(sig_s0_64));
    sha2_small_sigma #(.WORD_W(64), .SEL(1)) u_sig1_64 (.i_x(sig_x64), .o_y(sig_s1_64));

    assign ob_valid  = sel64 ? v64    : v32;
    assign ob_word   = sel64 ? wd64   : {32'h0, wd32};
    assign ob_index  = sel64 ? ix64   : ix32;
    assign ob_lready = sel64 ? lr64   : lr32;
    assign ob_busy   = sel64 ? busy64 : busy32;
    assign ob_done   = sel64 ? done64 : done32;
    assign ob_state  = sel64 ? st64   : st32;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model
    function automatic logic [63:0] rotr(input logic [63:0] x, input int r, input bit is64);
        if (is64) return (x >> r) | (x << (64 - r));
        return {32'h0, (x[31:0] >> r) | (x[31:0] << (32 - r))};
    endfunction

    function automatic logic [63:0] msig(input logic [63:0] x, input bit is64, input bit s1);
        if (is64)
            return s1 ? (rotr(x, 19, 1'b1) ^ rotr(x, 61, 1'b1) ^ (x >> 6))
                      : (rotr(x, 1, 1'b1) ^ rotr(x, 8, 1'b1) ^ (x >> 7));
        return s1 ? (rotr(x, 17, 1'b0) ^ rotr(x, 19, 1'b0) ^ (x >> 10))
                  : (rotr(x, 7, 1'b0) ^ rotr(x, 18, 1'b0) ^ (x >> 3));
    endfunction

    // Driver plus scoreboard: kind 0 = random, 1 = "abc", 2 = single-word block.
    task automatic run_blocks(input bit is64, input int nblk, input int kind, input bit rnd);
        int          rounds;
        int          total;
        int          nout;
        int          ndone;
        int          cyc;
        bit          prev_stall;
        bit          prev_final;
        bit          exp_done;
        logic [63:0] pw;
        logic [6:0]  pi;
        logic [63:0] s [80];
        rounds = is64 ? 80 : 64;
        nout = 0; ndone = 0; cyc = 0;
        prev_stall = 1'b0; prev_final = 1'b0; pw = '0; pi = '0;
        sel64 = is64;
        for (int b = 0; b < nblk; b++) begin
            for (int i = 0; i < 16; i++) begin
                case (kind)
                    0:       s[i] = is64 ? {$urandom, $urandom} : {32'h0, $urandom};
                    1:       s[i] = abc_w[i];
                    default: s[i] = (i == 0) ? 64'h0123456789ABCDEF : 64'h0;
                endcase
                load_q.push_back(s[i]);
            end
            for (int t = 16; t < rounds; t++) begin
                s[t] = msig(s[t-2], is64, 1'b1) + s[t-7] + msig(s[t-15], is64, 1'b0) + s[t-16];
                if (!is64) s[t][63:32] = 32'h0;
            end
            for (int t = 0; t < rounds; t++) exp_q.push_back(s[t]);
        end
        total = nblk * rounds;
        while (nout < total && cyc < 400 * nblk + 200) begin
            tb_lv = (load_q.size() > 0) && (!rnd || $urandom_range(0, 2) != 0);
            tb_lw = (load_q.size() > 0) ? load_q[0] : 64'h0;
            tb_wr = !rnd || ($urandom_range(0, 1) == 1);
            #1;
            if (prev_stall) begin
                check("hold_valid", 64'(ob_valid), 64'd1);
                check("hold_word", ob_word, pw);
                check("hold_index", 64'(ob_index), 64'(pi));
            end
            if (prev_final && !rnd) begin
                check("b2b_valid", 64'(ob_valid), 64'd1);
                check("b2b_index", 64'(ob_index), 64'd0);
            end
            prev_final = 1'b0;
            exp_done = ob_valid && tb_wr && ((nout % rounds) == rounds - 1);
            check("block_done", 64'(ob_done), 64'(exp_done));
            if (ob_done) ndone++;
            if (ob_valid && tb_wr) begin
                check("w_index", 64'(ob_index), 64'(nout % rounds));
                check("w_word", ob_word, exp_q.pop_front());
                cap[nout % rounds] = ob_word;
                prev_final = ((nout % rounds) == rounds - 1) && (nout + 1 < total);
                nout++;
            end
            prev_stall = ob_valid && !tb_wr;
            pw = ob_word;
            pi = ob_index;
            if (tb_lv && ob_lready) void'(load_q.pop_front());
            @(posedge clock);
            #1;
            cyc++;
        end
        tb_lv = 1'b0;
        tb_wr = 1'b1;
        #1;
        check("words_out", 64'(nout), 64'(total));
        check("done_count", 64'(ndone), 64'(nblk));
        check("idle_busy", 64'(ob_busy), 64'd0);
        exp_q.delete();
        load_q.delete();
    endtask

    // Start an "abc" block on the 32-bit unit, abort once t == n.
    task automatic abort_at(input int n, input bit use_reset);
        int nload;
        bit found;
        sel64 = 1'b0;
        nload = 0;
        found = 1'b0;
        for (int cyc = 0; cyc < 200 && !found; cyc++) begin
            tb_lv = (nload < 16);
            tb_lw = abc_w[nload % 16];
            tb_wr = 1'b1;
            #1;
            if (ob_valid && ob_index == 7'(n - 1)) begin
                found = 1'b1;
            end else begin
                if (tb_lv && ob_lready) nload++;
                @(posedge clock);
                #1;
            end
        end
        check("reach_t", 64'(found), 64'd1);
        if (use_reset) tb_reset = 1'b0;
        else tb_flush = 1'b1;
        #1;
        check("abort_no_done", 64'(ob_done), 64'd0);
        @(posedge clock);
        #1;
        tb_reset = 1'b1;
        tb_flush = 1'b0;
        tb_lv = 1'b0;
        #1;
        check("abort_valid", 64'(ob_valid), 64'd0);
        check("abort_busy", 64'(ob_busy), 64'd0);
        check("abort_state", 64'(ob_state), 64'd0);
        check("abort_done", 64'(ob_done), 64'd0);
        if (use_reset) begin
            check("reset_word", ob_word, 64'd0);
            check("reset_index", 64'(ob_index), 64'd0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        tb_reset = 1'b0;
        tb_flush = 1'b0;
        tb_lv = 1'b0;
        tb_lw = 64'h0;
        tb_wr = 1'b0;
        sel64 = 1'b0;
        for (int i = 0; i < 16; i++) abc_w[i] = 64'h0;
        abc_w[0]  = 64'h61626380;
        abc_w[15] = 64'h00000018;

        repeat (3) @(posedge clock);
        #1;
        for (int u = 0; u < 2; u++) begin
            sel64 = (u == 1);
            #1;
            check("rst_valid", 64'(ob_valid), 64'd0);
            check("rst_word", ob_word, 64'd0);
            check("rst_index", 64'(ob_index), 64'd0);
            check("rst_done", 64'(ob_done), 64'd0);
            check("rst_busy", 64'(ob_busy), 64'd0);
            check("rst_state", 64'(ob_state), 64'd0);
        end
        sel64 = 1'b0;
        tb_reset = 1'b1;

        sig_x32 = 32'h00000001;
        sig_x64 = 64'h1;
        #1;
        check("sig0_32", 64'(sig_s0_32), 64'h02004000);
        check("sig1_32", 64'(sig_s1_32), 64'h0000A000);
        check("sig0_64", sig_s0_64, 64'h8100000000000000);
        check("sig1_64", sig_s1_64, 64'h0000200000000008);

        @(posedge clock);
        #1;
        run_blocks(1'b0, 1, 1, 1'b0);
        check("abc_w0", cap[0], 64'h61626380);
        check("abc_w15", cap[15], 64'h00000018);
        check("abc_w16", cap[16], 64'h61626380);
        check("abc_w17", cap[17], 64'h000F0000);

        run_blocks(1'b0, 2, 0, 1'b0);
        run_blocks(1'b0, 100, 0, 1'b1);

        abort_at(5, 1'b0);
        abort_at(40, 1'b0);
        abort_at(30, 1'b1);
        run_blocks(1'b0, 1, 1, 1'b0);
        check("fresh_w16", cap[16], 64'h61626380);

        run_blocks(1'b1, 1, 2, 1'b0);
        check("w64_w0", cap[0], 64'h0123456789ABCDEF);
        check("w64_w16", cap[16], 64'h0123456789ABCDEF);
        check("w64_w17", cap[17], 64'h0);
        run_blocks(1'b1, 3, 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
